// File: rtl/ram_sdp_bw.sv
`default_nettype none
// ============================================================================
// Module      : ram_sdp_bw
// Description : Parametrised simple dual-port block RAM. Port A writes with
//               per-byte enables. Port B reads with a valid strobe and
//               forwards same-cycle write data on an address collision. A
//               clear sequencer zeroes every entry after reset or on request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DATA_W  word width (multiple of 8)
//               ADDR_W  address width, depth = 2**ADDR_W
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               clr        single-cycle request to re-zero the array
//               ena/wea/addra/dia   port A write (byte enables in wea)
//               enb/addrb           port B read request
//               dob/dob_valid       port B read data and valid pulse
//               busy       clear sequencer active
// Config      : RAM_SDP_BW_OUTREG_EN adds a second output register stage
//               (read latency 2 instead of 1).
// ============================================================================
module ram_sdp_bw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dia,
    input  logic                  enb,
    input  logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     dob,
    output logic                  dob_valid,
    output logic                  busy
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_NB    = DATA_W / 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_next;

    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_collide;
    logic [c_NB-1:0]     w_mem_be;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_fwd;

    logic [DATA_W-1:0]   r_dob1;
    logic                r_vld1;

    assign busy      = (r_state == S_CLEAR);
    assign w_rd_acc  = (r_state == S_READY) && enb;
    assign w_wr_acc  = (r_state == S_READY) && ena;
    assign w_collide = w_rd_acc && w_wr_acc && (addra == addrb);

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                // Counter wraps back to 0 on the last address, ready for
                // the next clear request.
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                if (clr) begin
                    w_state_next   = S_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            default: begin
                w_state_next   = S_CLEAR;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single array write port shared by the clear sequencer and port A
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_be   = '0;
        w_mem_addr = addra;
        w_mem_data = dia;
        if (!rst) begin
            if (busy) begin
                w_mem_be   = '1;
                w_mem_addr = r_clr_cnt;
                w_mem_data = '0;
            end else if (w_wr_acc) begin
                w_mem_be   = wea;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_addr][i*8 +: 8] <= w_mem_data[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port with write-first byte merge on collision
    // ------------------------------------------------------------------
    assign w_rd_word = r_mem[addrb];

    for (genvar gi = 0; gi < c_NB; gi++) begin : g_fwd
        assign w_fwd[gi*8 +: 8] = (w_collide && wea[gi]) ? dia[gi*8 +: 8]
                                                         : w_rd_word[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dob1 <= '0;
            r_vld1 <= 1'b0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_dob1 <= w_fwd;
            end
        end
    end

`ifdef RAM_SDP_BW_OUTREG_EN
    logic [DATA_W-1:0]   r_dob2;
    logic                r_vld2;

    // Second stage advances only on valid data so dob holds between reads;
    // it runs independently of the FSM so an in-flight read still emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dob2 <= '0;
            r_vld2 <= 1'b0;
        end else begin
            r_vld2 <= r_vld1;
            if (r_vld1) begin
                r_dob2 <= r_dob1;
            end
        end
    end

    assign dob       = r_dob2;
    assign dob_valid = r_vld2;
`else
    assign dob       = r_dob1;
    assign dob_valid = r_vld1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_bw.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sdp_bw
// Description : Self-checking bench for ram_sdp_bw (DATA_W=32, ADDR_W=10).
//               Table of directed read/write vectors plus hand sequences for
//               reset clearing, busy lockout and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sdp_bw;

`ifdef RAM_SDP_BW_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ena;
    logic [3:0]  wea;
    logic [9:0]  addra;
    logic [31:0] dia;
    logic        enb;
    logic [9:0]  addrb;
    logic [31:0] dob;
    logic        dob_valid;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ram_sdp_bw #(.DATA_W(32), .ADDR_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dia       (dia),
        .enb       (enb),
        .addrb     (addrb),
        .dob       (dob),
        .dob_valid (dob_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [3:0]  wea;
        logic [9:0]  addra;
        logic [31:0] dia;
        logic        enb;
        logic [9:0]  addrb;
        logic        exp_vld;
        logic        chk_dob;
        logic [31:0] exp_dob;
    } vec_t;

    localparam int N = 27;
    vec_t vecs [N];

    function automatic vec_t mk(input logic e, input logic [3:0] we,
                                input logic [9:0] aa, input logic [31:0] d,
                                input logic eb, input logic [9:0] ab,
                                input logic v, input logic c,
                                input logic [31:0] x);
        vec_t r;
        r.ena = e; r.wea = we; r.addra = aa; r.dia = d;
        r.enb = eb; r.addrb = ab; r.exp_vld = v; r.chk_dob = c; r.exp_dob = x;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; wea = '0; addra = '0; dia = '0;
        enb = 1'b0; addrb = '0; clr = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 3000) begin
            n++;
            step();
        end
    endtask

    task automatic read_check(input logic [9:0] a, input logic [31:0] exp,
                              input string name);
        enb = 1'b1; addrb = a;
        step();
        enb = 1'b0;
        repeat (LAT - 1) step();
        chk({name, "_vld"}, {31'b0, dob_valid}, 32'd1);
        chk(name, dob, exp);
    endtask

    initial begin
        int k;
        int n;
        logic seen_vld;

        // R = read, W = write, C = collision
        vecs[0]  = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd0,    1, 1, 32'h0);
        vecs[1]  = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd511,  1, 1, 32'h0);
        vecs[2]  = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd1023, 1, 1, 32'h0);
        vecs[3]  = mk(1, 4'hF, 10'd5,   32'h11223344, 0, 10'd0,    0, 0, 32'h0);
        vecs[4]  = mk(1, 4'h5, 10'd5,   32'hAABBCCDD, 0, 10'd0,    0, 0, 32'h0);
        vecs[5]  = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd5,    1, 1, 32'h11BB33DD);
        vecs[6]  = mk(1, 4'h0, 10'd5,   32'h77777777, 0, 10'd0,    0, 0, 32'h0);
        vecs[7]  = mk(0, 4'hF, 10'd5,   32'h0,        1, 10'd1023, 1, 1, 32'h0);
        vecs[8]  = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd5,    1, 1, 32'h11BB33DD);
        vecs[9]  = mk(1, 4'hF, 10'd23,  32'h00000063, 0, 10'd0,    0, 0, 32'h0);
        vecs[10] = mk(1, 4'h3, 10'd23,  32'h0000005F, 1, 10'd23,   1, 1, 32'h0000005F);
        vecs[11] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd23,   1, 1, 32'h0000005F);
        vecs[12] = mk(1, 4'hF, 10'd30,  32'hDEADBEEF, 0, 10'd0,    0, 0, 32'h0);
        vecs[13] = mk(1, 4'hA, 10'd30,  32'h12345678, 1, 10'd30,   1, 1, 32'h12AD56EF);
        vecs[14] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd30,   1, 1, 32'h12AD56EF);
        vecs[15] = mk(1, 4'hF, 10'd0,   32'd10,       0, 10'd0,    0, 0, 32'h0);
        vecs[16] = mk(1, 4'hF, 10'd1,   32'd11,       0, 10'd0,    0, 0, 32'h0);
        vecs[17] = mk(1, 4'hF, 10'd2,   32'd12,       0, 10'd0,    0, 0, 32'h0);
        vecs[18] = mk(1, 4'hF, 10'd3,   32'd13,       0, 10'd0,    0, 0, 32'h0);
        vecs[19] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd0,    1, 1, 32'd10);
        vecs[20] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd1,    1, 1, 32'd11);
        vecs[21] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd2,    1, 1, 32'd12);
        vecs[22] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd3,    1, 1, 32'd13);
        vecs[23] = mk(0, 4'h0, 10'd0,   32'h0,        0, 10'd0,    0, 1, 32'd13);
        vecs[24] = mk(1, 4'hF, 10'd40,  32'hCAFEF00D, 1, 10'd41,   1, 1, 32'h0);
        vecs[25] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd40,   1, 1, 32'hCAFEF00D);
        vecs[26] = mk(0, 4'h0, 10'd0,   32'h0,        1, 10'd5,    1, 1, 32'h11BB33DD);

        // ---------------- reset and initial clear ----------------
        idle();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_vld", {31'b0, dob_valid}, 32'd0);
        chk("rst_dob", dob, 32'h0);
        rst = 1'b0;
        count_busy(n);
        chk("init_clear_cycles", n, 32'd1024);

        // ---------------- table-driven vectors ----------------
        for (int c = 0; c < N + LAT - 1; c++) begin
            if (c < N) begin
                ena = vecs[c].ena; wea = vecs[c].wea; addra = vecs[c].addra;
                dia = vecs[c].dia; enb = vecs[c].enb; addrb = vecs[c].addrb;
            end else begin
                idle();
            end
            step();
            k = c - (LAT - 1);
            if (k >= 0) begin
                chk($sformatf("vec%0d_vld", k), {31'b0, dob_valid},
                    {31'b0, vecs[k].exp_vld});
                if (vecs[k].chk_dob)
                    chk($sformatf("vec%0d_dob", k), dob, vecs[k].exp_dob);
            end
        end
        idle();

        // ---------------- reset during a read ----------------
        enb = 1'b1; addrb = 10'd5; rst = 1'b1;
        step();
        chk("rstrd_dob", dob, 32'h0);
        chk("rstrd_vld", {31'b0, dob_valid}, 32'd0);
        chk("rstrd_busy", {31'b0, busy}, 32'd1);
        enb = 1'b0; rst = 1'b0;
        count_busy(n);
        chk("rstrd_clear_cycles", n, 32'd1024);

        // ---------------- busy lockout ----------------
        ena = 1'b1; wea = 4'hF; addra = 10'd0; dia = 32'd95;
        step();
        idle();
        // Read issued together with clr must still complete.
        clr = 1'b1; enb = 1'b1; addrb = 10'd0;
        step();
        clr = 1'b0;
        ena = 1'b1; wea = 4'hF; addra = 10'd0; dia = 32'd7;
        repeat (LAT - 1) step();
        chk("clr_rd_vld", {31'b0, dob_valid}, 32'd1);
        chk("clr_rd_dob", dob, 32'd95);
        chk("lock_busy", {31'b0, busy}, 32'd1);
        seen_vld = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            n++;
            step();
            if (busy && dob_valid) seen_vld = 1'b1;
        end
        idle();
        chk("lock_timeout", {31'b0, busy}, 32'd0);
        chk("lock_vld_during_busy", {31'b0, seen_vld}, 32'd0);
        read_check(10'd0, 32'h0, "lock_addr0");

        // ---------------- reset mid-clear ----------------
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (300) step();
        rst = 1'b1;
        step();
        chk("rstclr_busy", {31'b0, busy}, 32'd1);
        chk("rstclr_vld", {31'b0, dob_valid}, 32'd0);
        chk("rstclr_dob", dob, 32'h0);
        rst = 1'b0;
        count_busy(n);
        chk("rstclr_clear_cycles", n, 32'd1024);
        read_check(10'd5, 32'h0, "final_addr5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_sdp_bw.md
# ram_sdp_bw

Parametrised simple dual-port block RAM, successor to the fixed 1024x32 SDP RAM, for buffering samples and coefficients between accelerator stages. Port A writes with per-byte enables. Port B reads with a valid strobe and forwards same-cycle write data on an address collision. A built-in clear sequencer zeroes every entry after reset or on request, and reports busy while it runs.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width. Derived depth DEPTH = 2**ADDR_W; derived byte count NB = DATA_W/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  single-cycle request to re-zero the whole array.
- ena  in  1  port A enable.
- wea  in  NB  port A byte write enables; bit i covers dia[8i+7:8i].
- addra  in  ADDR_W  port A address.
- dia  in  DATA_W  port A write data.
- enb  in  1  port B read enable.
- addrb  in  ADDR_W  port B address.
- dob  out  DATA_W  port B read data.
- dob_valid  out  1  dob holds the data of a newly accepted read.
- busy  out  1  clear sequencer is active.

## Operation
- The FSM has two states, CLEAR and READY.
- rst=1: state goes to CLEAR and the clear counter goes to 0. Reset values: dob=0, dob_valid=0, busy=1.
- CLEAR: each cycle, write 0 to ram[clr_cnt], then increment clr_cnt. When clr_cnt==DEPTH-1 is written, go to READY on the next edge.
  - While rst stays high, the counter holds at 0.
  - Clearing takes exactly DEPTH cycles after rst falls.
- READY and clr=1: go to CLEAR with clr_cnt=0. clr is ignored while already in CLEAR.
- busy = (state==CLEAR).
- While busy, port A writes and port B reads are ignored: no array update, and dob_valid=0. dob holds its last value.
- Write is accepted when READY & ena. Byte i is written only where wea[i]=1. If wea==0, nothing is written.
- Read is accepted when READY & enb. ena does not affect port B.
- Collision (accepted read, accepted write, addra==addrb): dob byte i = wea[i] ? dia byte i : old ram byte i. This is write-first behaviour with byte merge.
- No accepted read: dob holds its value and dob_valid=0.
- A clr in the same cycle as an accepted read or write: that read and write complete normally, and CLEAR starts on the following cycle.
- rst mid-clear or mid-read: rst overrides. The pipeline is flushed, dob=0, and the clear restarts from address 0.

## Timing
- Write latency: an accepted write at edge N is visible to a read issued at edge N+1.
- Read latency is 1 cycle: a read accepted at edge N gives dob and dob_valid=1 after edge N+1.
- A read on each cycle gives a result on each cycle, with no bubbles.
- dob_valid is a pulse for each accepted read. It is never high while busy unless the read was accepted before CLEAR started.
- busy falls on the edge that leaves CLEAR. The first accepted read or write can be in that same cycle.

## Configuration
- Macro: RAM_SDP_BW_OUTREG_EN.
- Defined: adds a second output register stage. Read latency becomes 2 cycles, and dob_valid is delayed with it. The extra stage resets to 0 on rst.
  - Collision forwarding is captured in stage 1, so it behaves the same as the undefined case, one cycle later.
  - A read in flight when clr is accepted still emerges.
- Undefined: single-stage read as described above.

## Test plan
- Reset clear: hold rst for 3 cycles, then release. Required: busy=1 for exactly 1024 cycles after release, then 0. A read of addresses 0, 511 and 1023 returns 0 with dob_valid=1 one cycle later.
- Byte write: write 0x11223344 to address 5 with wea=4'b1111, then 0xAABBCCDD with wea=4'b0101. Required: reading address 5 gives 0x11BB33DD.
- Collision: ram[23]=0x00000063 is preloaded. In one cycle: ena=1, wea=4'b0011, addra=23, dia=0x0000005F, enb=1, addrb=23. Required: dob=0x0000005F next cycle, and ram[23] reads 0x0000005F afterwards.
- Busy lockout: write 95 to address 0, pulse clr, then during busy attempt a write of 7 to address 0 and a read. Required: dob_valid stays 0 during busy. After busy falls, address 0 reads 0.
- Back-to-back reads: with enb held high, step addrb through 0, 1, 2, 3, preloaded with 10, 11, 12, 13. Required: dob is 10, 11, 12, 13 on four consecutive cycles with dob_valid=1. With RAM_SDP_BW_OUTREG_EN, the same sequence appears one cycle later.
- Reset mid-operation: assert rst during clear address 300 and during a read. Required: dob=0 and dob_valid=0 next cycle, and busy lasts a full 1024 cycles after rst falls.
